mem_stage_sram_ctrl: RTL and testbench
======================================

Name: mem_stage_sram_ctrl

Overview:
- Consumer end of the EX→MEM pipeline register; takes its outputs and performs data-memory accesses to an external 16-bit SRAM.
- Splits each 32-bit load/store into two half-word SRAM transactions with programmable wait states.
- Raises a stall toward the earlier stages while an access is in flight.
- Contains the MEM→WB pipeline register feeding write-back.

Parameters:
REGISTER_LEN, 32, data/address word width
REG_ADDRESS_LEN, 4, destination register index width
SRAM_ADDR_LEN, 18, SRAM half-word address width
WAIT_CYCLES, 1, extra SRAM cycles per half-word phase (0..7)
ADDR_OFFSET, 1024, byte address mapped to SRAM word 0

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
wb_en_in  in  1  write-back enable from EX→MEM register
mem_r_en_in  in  1  load request
mem_w_en_in  in  1  store request
alu_res_in  in  REGISTER_LEN  effective byte address, or ALU result for non-memory ops
val_Rm_in  in  REGISTER_LEN  store data
dest_in  in  REG_ADDRESS_LEN  destination register
freeze_out  out  1  stall request to IF/ID/EX and the hazard unit
wb_en_out  out  1  MEM→WB write-back enable
mem_r_en_out  out  1  MEM→WB load flag (selects mem_data in WB)
alu_res_out  out  REGISTER_LEN  MEM→WB ALU result
mem_data_out  out  REGISTER_LEN  MEM→WB load data
dest_out  out  REG_ADDRESS_LEN  MEM→WB destination
sram_addr  out  SRAM_ADDR_LEN  SRAM half-word address
sram_dq_out  out  16  SRAM write data
sram_dq_oe  out  1  drive enable for the SRAM data pads
sram_dq_in  in  16  SRAM read data
sram_we_n  out  1  SRAM write strobe, active-low

Behaviour:
- States: IDLE, LOW, HIGH, DONE. A phase counter counts 0..WAIT_CYCLES.
- Request: req = mem_r_en_in | mem_w_en_in. If both are high, treat it as a store and force mem_r_en_out=0.
- Address:
  - word = (alu_res_in − ADDR_OFFSET) >> 2, truncated to SRAM_ADDR_LEN−1 bits; wrap-around is silent, no range check.
  - LOW phase: sram_addr = {word,0}, carries bits [15:0].
  - HIGH phase: sram_addr = {word,1}, carries bits [31:16].
- State transitions:
  - IDLE with req → LOW, counter=0. IDLE without req stays IDLE.
  - LOW and HIGH each last WAIT_CYCLES+1 cycles, then advance (LOW→HIGH→DONE).
  - DONE → IDLE unconditionally.
- Store:
  - sram_dq_oe=1 and sram_we_n=0 for every cycle of LOW and HIGH; sram_dq_out holds the matching val_Rm_in half.
  - sram_we_n=1 in all other states.
- Load:
  - sram_dq_oe=0.
  - sram_dq_in is captured into an internal 32-bit buffer on the last cycle of LOW (low half) and of HIGH (high half).
- Stall: freeze_out = req & (state≠DONE), combinational. Upstream registers therefore hold the inputs stable for the whole access.
- Latency with WAIT_CYCLES=1: freeze_out high for 5 cycles (IDLE + 2 LOW + 2 HIGH), low in DONE. The MEM→WB register loads at the end of DONE.
- Non-memory instructions (req=0): no stall; the MEM→WB register loads every cycle, latency 1.
- MEM→WB register:
  - Loads every cycle.
  - While freeze_out=1 it loads a bubble: wb_en_out=0, mem_r_en_out=0, other fields unchanged.
  - Otherwise it loads the inputs, with mem_data_out = assembled buffer (store/non-load: the buffer value is don't-care but stable).
- Reset (any time, including mid-access):
  - State returns to IDLE and the counter clears.
  - All MEM→WB outputs are 0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - freeze_out follows the combinational rule: 0 unless req is high.

Optional Feature:
- MEM_READ_BUF_EN defined:
  - A one-entry read buffer (valid bit, word address, data) is added.
  - Load hitting a valid entry: IDLE goes directly to DONE. freeze_out is high for 1 cycle only, and data comes from the buffer.
  - Completed load: fills the entry.
  - Completed store to the same word: updates the entry's data.
  - Store to a different word: leaves the entry unchanged.
  - Reset clears the valid bit.
- MEM_READ_BUF_EN undefined: no buffer; every load takes the full SRAM sequence.

Test Plan:
- Reset mid-access: assert rst low during HIGH of a store → sram_we_n=1, sram_dq_oe=0 and all outputs 0 immediately; after release the state is IDLE, with no SRAM activity until the next req.
- ALU op (WAIT_CYCLES=1): wb_en_in=1, alu_res_in=0x0000_1234, dest_in=5 → freeze_out stays 0; next cycle wb_en_out=1, alu_res_out=0x1234, dest_out=5.
- Store: alu_res_in=1024+8, val_Rm_in=0xDEADBEEF → freeze_out high 5 cycles; sram_addr=4 with dq=0xBEEF for 2 cycles, then addr=5 with dq=0xDEAD for 2 cycles; wb_en_out stays 0.
- Load after that store: same address, mem_r_en_in=1, dest_in=3, wb_en_in=1 → after 6 cycles mem_data_out=0xDEADBEEF, mem_r_en_out=1, dest_out=3; bubbles (wb_en_out=0) during the stall.
- Back-to-back loads to addresses 1024 and 1028 → two full 6-cycle sequences, sram_addr 0,1 then 2,3; no lost or duplicated write-back.
- MEM_READ_BUF_EN: repeat the load of 1028 → freeze_out high 1 cycle, no SRAM activity, correct data. Then store 0x11112222 to 1028 and reload → returns 0x11112222.

Source files
------------

// File: rtl/mem_stage_sram_ctrl_if.sv
// mem_stage_sram_ctrl_if: 16-bit asynchronous SRAM bus
// master = MEM-stage controller, slave = SRAM device
interface mem_stage_sram_ctrl_if #(
  parameter int AW = 18
) ();
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;
  logic          sram_we_n;

  modport master (
    output sram_addr,
    output sram_dq_out,
    output sram_dq_oe,
    output sram_we_n,
    input  sram_dq_in
  );

  modport slave (
    input  sram_addr,
    input  sram_dq_out,
    input  sram_dq_oe,
    input  sram_we_n,
    output sram_dq_in
  );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: MEM stage, 32-bit accesses as two 16-bit SRAM phases
// Optional one-entry read buffer enabled by defining MEM_READ_BUF_EN
module mem_stage_sram_ctrl #(
  parameter int REGISTER_LEN    = 32,
  parameter int REG_ADDRESS_LEN = 4,
  parameter int SRAM_ADDR_LEN   = 18,
  parameter int WAIT_CYCLES     = 1,
  parameter int ADDR_OFFSET     = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_en_in,
  input  logic                       mem_r_en_in,
  input  logic                       mem_w_en_in,
  input  logic [REGISTER_LEN-1:0]    alu_res_in,
  input  logic [REGISTER_LEN-1:0]    val_Rm_in,
  input  logic [REG_ADDRESS_LEN-1:0] dest_in,
  output logic                       freeze_out,
  output logic                       wb_en_out,
  output logic                       mem_r_en_out,
  output logic [REGISTER_LEN-1:0]    alu_res_out,
  output logic [REGISTER_LEN-1:0]    mem_data_out,
  output logic [REG_ADDRESS_LEN-1:0] dest_out,
  mem_stage_sram_ctrl_if.master      sram
);

  localparam int WL = SRAM_ADDR_LEN - 1;
  localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t st, st_n;
  logic [2:0] cnt, cnt_n;
  logic [WL-1:0] word;
  logic [REGISTER_LEN-1:0] rd_buf;
  logic req, is_st, is_ld, last, hit;

  assign req   = mem_r_en_in | mem_w_en_in;
  assign is_st = mem_w_en_in;
  assign is_ld = mem_r_en_in & ~mem_w_en_in;
  assign last  = (cnt == LAST);
  assign word  = WL'((alu_res_in - REGISTER_LEN'(ADDR_OFFSET)) >> 2);

  assign freeze_out = req & (st != DONE);

`ifdef MEM_READ_BUF_EN
  logic                    rb_valid;
  logic [WL-1:0]           rb_word;
  logic [REGISTER_LEN-1:0] rb_data;

  assign hit = is_ld & rb_valid & (rb_word == word);

  // Completed loads fill the entry; stores to the held word keep it coherent
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rb_valid <= 1'b0;
      rb_word  <= '0;
      rb_data  <= '0;
    end else if (st == DONE) begin
      if (is_st) begin
        if (rb_valid && rb_word == word)
          rb_data <= val_Rm_in;
      end else if (is_ld) begin
        rb_valid <= 1'b1;
        rb_word  <= word;
        rb_data  <= rd_buf;
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st  <= IDLE;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

  always_comb begin
    st_n = st;
    cnt_n = cnt;
    sram.sram_addr = '0;
    sram.sram_dq_out = '0;
    sram.sram_dq_oe = 1'b0;
    sram.sram_we_n = 1'b1;
    unique case (st)
      IDLE: begin
        if (req) begin
          st_n = hit ? DONE : LOW;
          cnt_n = '0;
        end
      end
      LOW: begin
        sram.sram_addr = {word, 1'b0};
        sram.sram_dq_out = val_Rm_in[15:0];
        sram.sram_dq_oe = is_st;
        sram.sram_we_n = ~is_st;
        cnt_n = last ? 3'd0 : cnt + 3'd1;
        if (last) st_n = HIGH;
      end
      HIGH: begin
        sram.sram_addr = {word, 1'b1};
        sram.sram_dq_out = val_Rm_in[31:16];
        sram.sram_dq_oe = is_st;
        sram.sram_we_n = ~is_st;
        cnt_n = last ? 3'd0 : cnt + 3'd1;
        if (last) st_n = DONE;
      end
      DONE: st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  // Read data is sampled at the end of each phase, after the wait states
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_buf <= '0;
    end else begin
`ifdef MEM_READ_BUF_EN
      if (st == IDLE && hit)
        rd_buf <= rb_data;
`endif
      if (st == LOW && last && is_ld)
        rd_buf[15:0] <= sram.sram_dq_in;
      if (st == HIGH && last && is_ld)
        rd_buf[31:16] <= sram.sram_dq_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
      dest_out     <= '0;
    end else if (freeze_out) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
    end else begin
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= is_ld;
      alu_res_out  <= alu_res_in;
      mem_data_out <= rd_buf;
      dest_out     <= dest_in;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// tb_mem_stage_sram_ctrl: scoreboard bench with a behavioural 16-bit SRAM
// Covers reset, ALU pass-through, stores, loads, address wrap and read buffer
module tb_mem_stage_sram_ctrl;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, val_Rm_in;
  logic [3:0]  dest_in;
  logic        freeze_out, wb_en_out, mem_r_en_out;
  logic [31:0] alu_res_out, mem_data_out;
  logic [3:0]  dest_out;

  mem_stage_sram_ctrl_if #(.AW(18)) sram_bus ();

  mem_stage_sram_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en_in     (wb_en_in),
    .mem_r_en_in  (mem_r_en_in),
    .mem_w_en_in  (mem_w_en_in),
    .alu_res_in   (alu_res_in),
    .val_Rm_in    (val_Rm_in),
    .dest_in      (dest_in),
    .freeze_out   (freeze_out),
    .wb_en_out    (wb_en_out),
    .mem_r_en_out (mem_r_en_out),
    .alu_res_out  (alu_res_out),
    .mem_data_out (mem_data_out),
    .dest_out     (dest_out),
    .sram         (sram_bus)
  );

  always #5 clk = ~clk;

  logic [15:0] sram_mem [0:(1<<18)-1];

  assign sram_bus.sram_dq_in = sram_mem[sram_bus.sram_addr];

  always @(posedge clk)
    if (!sram_bus.sram_we_n)
      sram_mem[sram_bus.sram_addr] <= sram_bus.sram_dq_out;

  typedef struct {
    logic        wb;
    logic        mr;
    logic        ld;
    logic [31:0] alu;
    logic [31:0] data;
    logic [3:0]  dest;
  } wb_t;

  wb_t exp_q[$];
  logic [31:0] mdl [int];
  bit          bv;
  logic [16:0] bw;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] hw_init(int a);
    return 16'(a * 61 + 4951);
  endfunction

  function automatic logic [31:0] mdl_rd(int w);
    if (mdl.exists(w)) return mdl[w];
    return {hw_init(2 * w + 1), hw_init(2 * w)};
  endfunction

  task automatic sram_expect(input int n, input logic [16:0] wd,
                             input logic st, input logic [31:0] val);
    logic ph_lo, ph_hi;
    ph_lo = (n >= 1) && (n <= W + 1);
    ph_hi = (n >= W + 2) && (n <= 2 * W + 2);
    if (ph_lo || ph_hi) begin
      chk("sram_addr", sram_bus.sram_addr, {wd, ph_hi});
      chk("sram_we_n", sram_bus.sram_we_n, !st);
      chk("sram_oe", sram_bus.sram_dq_oe, st);
      if (st)
        chk("sram_dq", sram_bus.sram_dq_out,
            ph_hi ? val[31:16] : val[15:0]);
    end else begin
      chk("idle_we_n", sram_bus.sram_we_n, 1'b1);
      chk("idle_oe", sram_bus.sram_dq_oe, 1'b0);
    end
  endtask

  task automatic issue(input logic wb, input logic r, input logic w,
                       input logic [31:0] alu, input logic [31:0] val,
                       input logic [3:0] dest);
    logic [16:0] wd;
    logic st, ld, rq, hit;
    int exp_n, n;
    wb_t e;
    wd = 17'((alu - 32'd1024) >> 2);
    st = w;
    ld = r & ~w;
    rq = r | w;
`ifdef MEM_READ_BUF_EN
    hit = ld && bv && (bw == wd);
`else
    hit = 1'b0;
`endif
    exp_n = !rq ? 0 : hit ? 1 : 2 * W + 3;
    e.wb = wb;
    e.mr = ld;
    e.ld = ld;
    e.alu = alu;
    e.data = ld ? mdl_rd(int'(wd)) : 32'h0;
    e.dest = dest;
    exp_q.push_back(e);
    wb_en_in = wb;
    mem_r_en_in = r;
    mem_w_en_in = w;
    alu_res_in = alu;
    val_Rm_in = val;
    dest_in = dest;
    #1;
    n = 0;
    while (freeze_out && n < 40) begin
      sram_expect(n, wd, st, val);
      @(posedge clk);
      @(negedge clk);
      n++;
      chk("bubble_wb", wb_en_out, 1'b0);
      chk("bubble_mr", mem_r_en_out, 1'b0);
    end
    chk("stall_len", n, exp_n);
    chk("done_we_n", sram_bus.sram_we_n, 1'b1);
    @(posedge clk);
    #1;
    if (st) mdl[int'(wd)] = val;
    if (ld) begin
      bv = 1'b1;
      bw = wd;
    end
    e = exp_q.pop_front();
    chk("wb_en_out", wb_en_out, e.wb);
    chk("mem_r_en_out", mem_r_en_out, e.mr);
    chk("alu_res_out", alu_res_out, e.alu);
    chk("dest_out", dest_out, e.dest);
    if (e.ld) chk("mem_data_out", mem_data_out, e.data);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_wb"}, wb_en_out, 1'b0);
    chk({tag, "_mr"}, mem_r_en_out, 1'b0);
    chk({tag, "_alu"}, alu_res_out, 32'h0);
    chk({tag, "_data"}, mem_data_out, 32'h0);
    chk({tag, "_dest"}, dest_out, 4'h0);
    chk({tag, "_addr"}, sram_bus.sram_addr, 18'h0);
    chk({tag, "_dq"}, sram_bus.sram_dq_out, 16'h0);
    chk({tag, "_oe"}, sram_bus.sram_dq_oe, 1'b0);
    chk({tag, "_we_n"}, sram_bus.sram_we_n, 1'b1);
  endtask

  initial begin
    for (int a = 0; a < (1 << 18); a++) sram_mem[a] = hw_init(a);
    bv = 1'b0;
    bw = '0;
    rst = 1'b0;
    wb_en_in = 1'b0;
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b0;
    alu_res_in = '0;
    val_Rm_in = '0;
    dest_in = '0;
    repeat (2) @(negedge clk);
    reset_checks("rst");
    chk("rst_freeze", freeze_out, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    issue(1, 0, 0, 32'h0000_1234, 32'h0, 4'd5);
    issue(0, 0, 1, 32'd1032, 32'hDEAD_BEEF, 4'd0);
    issue(1, 1, 0, 32'd1032, 32'h0, 4'd3);
    issue(1, 1, 0, 32'd1024, 32'h0, 4'd7);
    issue(1, 1, 0, 32'd1028, 32'h0, 4'd8);
    issue(1, 1, 0, 32'd1028, 32'h0, 4'd9);
    issue(0, 0, 1, 32'd1028, 32'h1111_2222, 4'd0);
    issue(1, 1, 0, 32'd1028, 32'h0, 4'd10);
    issue(1, 1, 1, 32'd1040, 32'h55AA_33CC, 4'd6);
    issue(1, 1, 0, 32'd1040, 32'h0, 4'd11);
    issue(0, 0, 1, 32'h0, 32'hCAFE_F00D, 4'd0);
    issue(1, 1, 0, 32'h0, 32'h0, 4'd12);
    issue(1, 0, 0, 32'hFFFF_FFFF, 32'h0, 4'd15);

    // reset in the HIGH phase of a store
    wb_en_in = 1'b0;
    mem_r_en_in = 1'b0;
    mem_w_en_in = 1'b1;
    alu_res_in = 32'd1088;
    val_Rm_in = 32'h7777_8888;
    dest_in = 4'd2;
    repeat (3) @(negedge clk);
    chk("mid_addr", sram_bus.sram_addr, {17'd16, 1'b1});
    chk("mid_we_n", sram_bus.sram_we_n, 1'b0);
    rst = 1'b0;
    #1;
    reset_checks("midrst");
    mem_w_en_in = 1'b0;
    #1;
    chk("midrst_freeze", freeze_out, 1'b0);
    bv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_we_n", sram_bus.sram_we_n, 1'b1);
      chk("post_rst_addr", sram_bus.sram_addr, 18'h0);
      chk("post_rst_freeze", freeze_out, 1'b0);
    end
    issue(1, 1, 0, 32'd1028, 32'h0, 4'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
